ctrl_resolve_queue: RTL and testbench
=====================================

CTRL_RESOLVE_QUEUE -- requirements
Module: ctrl_resolve_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; power of two, at least 2.
REQ-002 Parameter PC_W, default `SIZE_PC, width of the PC and next-PC fields.
REQ-003 Parameter TYPE_W, default `BRANCH_TYPE_LOG, width of the control-type field.
REQ-004 Parameter CTI_W, default `SIZE_CTI_LOG, width of the CTI ID field.
REQ-005 Parameter AFULL_TH, default DEPTH-2, occupancy at or above which almostFull_o SHALL assert.
REQ-006 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 recoverFlag_i  in  1  pipeline recovery; suppresses the push in the same cycle.
REQ-009 exeCtrlValid_i  in  1  resolved control instruction present from writeback.
REQ-010 exeCtrlPC_i  in  PC_W  PC of the resolved control instruction.
REQ-011 exeCtrlType_i  in  TYPE_W  branch type.
REQ-012 exeCtrlNPC_i  in  PC_W  resolved next PC.
REQ-013 exeCtrlDir_i  in  1  resolved direction, 1 = taken.
REQ-014 exeCtiID_i  in  CTI_W  CTI queue ID.
REQ-015 updValid_o  out  1  head entry valid toward the predictor update port.
REQ-016 updReady_i  in  1  predictor accepts the head entry this cycle.
REQ-017 updPC_o / updType_o / updNPC_o / updDir_o / updCtiID_o  out  PC_W / TYPE_W / PC_W / 1 / CTI_W  head entry fields.
REQ-018 count_o  out  log2(DEPTH)+1  current occupancy.
REQ-019 almostFull_o  out  1  count_o >= AFULL_TH.
REQ-020 overflow_o  out  1  sticky flag: a push was dropped because the queue was full.

Function
REQ-021 Push condition: exeCtrlValid_i & ~recoverFlag_i.
REQ-022 Pop condition: updValid_o & updReady_i.
REQ-023 The queue SHALL accept a push when count_o < DEPTH, or when count_o == DEPTH and a pop occurs in the same cycle.
REQ-024 Write behaviour:
- Entry written at wrPtr.
- Fields captured: PC, type, NPC, dir, CTI ID.
- wrPtr increments modulo DEPTH.
REQ-025 Pop behaviour: rdPtr increments modulo DEPTH; the head entry's contents are not cleared.
REQ-026 Occupancy update:
- Push only: count_o +1.
- Pop only: count_o -1.
- Push and pop together: count_o unchanged.
REQ-027 Latency: an entry pushed at edge N SHALL drive updValid_o and the upd*_o fields from cycle N+1. There is no combinational path from exe* inputs to upd*_o.
REQ-028 updValid_o SHALL equal (count_o != 0); upd*_o SHALL reflect the entry at rdPtr.
REQ-029 Ordering: entries SHALL pop in strict FIFO push order.
REQ-030 Handshake: while updValid_o=1 and updReady_i=0, upd*_o SHALL hold stable.
REQ-031 Full-queue drop: a push arriving at count_o == DEPTH with no pop in that cycle SHALL be dropped; pointers and count_o are unchanged, and overflow_o SHALL set to 1.
REQ-032 recoverFlag_i SHALL NOT alter stored entries, pointers, pops, or overflow_o. Resolved branches remain valid training data.
REQ-033 updReady_i while updValid_o=0 SHALL have no effect.
REQ-034 Pointer wrap: wrap-around from DEPTH-1 to 0 SHALL be seamless; full vs empty is distinguished by count_o.

Reset
REQ-035 While reset=0, asynchronously and regardless of clk:
- wrPtr=0, rdPtr=0, count_o=0.
- updValid_o=0, almostFull_o=0 (AFULL_TH>0), overflow_o=0.
- upd*_o data fields =0.
REQ-036 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion lands in entry 0.
REQ-037 overflow_o SHALL clear only on reset.

Verification
REQ-038 Basic push: reset, then push PC=0x1000, NPC=0x1004, dir=0, cti=3 with updReady_i=0 -> next cycle updValid_o=1, updPC_o=0x1000, count_o=1; holds for 5 cycles.
REQ-039 Fill and drop: push 9 entries (PC 0x0..0x20, step 4) with updReady_i=0 and DEPTH=8 -> count_o=8, overflow_o=1, almostFull_o=1 from count 6; drain yields PCs 0x0..0x1C in order, and 0x20 is never output.
REQ-040 Simultaneous push and pop at full: count_o=8, push PC=0xA0 with updReady_i=1 -> count_o stays 8, overflow_o stays 0, 0xA0 is output after the 7 older entries.
REQ-041 Recover: exeCtrlValid_i=1 with recoverFlag_i=1 -> no push and count_o unchanged; existing entries still drain normally.
REQ-042 Wrap and async reset: 20 push/pop pairs -> outputs in order across pointer wrap; then assert reset mid-cycle with 3 entries queued -> updValid_o=0 and count_o=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ctrl_resolve_queue.sv
// ctrl_resolve_queue
//   FIFO of resolved control instructions from writeback. Entries are
//   drained in order toward the branch predictor update port.
//
// Ports
//   clk, reset                   clock, async active-low reset
//   recoverFlag_i                pipeline recovery; blocks this cycle's push
//   exeCtrl*_i, exeCtiID_i       resolved control instruction (push side)
//   updValid_o / updReady_i      head valid / predictor accept (pop side)
//   upd*_o                       head entry fields
//   count_o                      occupancy
//   almostFull_o                 count_o >= AFULL_TH
//   overflow_o                   sticky: a push was dropped while full

`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef BRANCH_TYPE_LOG
`define BRANCH_TYPE_LOG 2
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

module ctrl_resolve_queue #(
  parameter int DEPTH    = 8,
  parameter int PC_W     = `SIZE_PC,
  parameter int TYPE_W   = `BRANCH_TYPE_LOG,
  parameter int CTI_W    = `SIZE_CTI_LOG,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       recoverFlag_i,
  input  logic                       exeCtrlValid_i,
  input  logic [PC_W-1:0]            exeCtrlPC_i,
  input  logic [TYPE_W-1:0]          exeCtrlType_i,
  input  logic [PC_W-1:0]            exeCtrlNPC_i,
  input  logic                       exeCtrlDir_i,
  input  logic [CTI_W-1:0]           exeCtiID_i,
  output logic                       updValid_o,
  input  logic                       updReady_i,
  output logic [PC_W-1:0]            updPC_o,
  output logic [TYPE_W-1:0]          updType_o,
  output logic [PC_W-1:0]            updNPC_o,
  output logic                       updDir_o,
  output logic [CTI_W-1:0]           updCtiID_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       almostFull_o,
  output logic                       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [TYPE_W-1:0] typ;
    logic [PC_W-1:0]   npc;
    logic              dir;
    logic [CTI_W-1:0]  cti;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  entry_t             wr_ent;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic               push, pop, full, accept, drop;

  assign push   = exeCtrlValid_i & ~recoverFlag_i;
  assign pop    = updValid_o & updReady_i;
  assign full   = (count == FULL_C);
  // A pop frees the head slot in the same edge, so a full queue still
  // takes a push when the predictor is draining.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign wr_ent = '{pc: exeCtrlPC_i, typ: exeCtrlType_i, npc: exeCtrlNPC_i,
                    dir: exeCtrlDir_i, cti: exeCtiID_i};

  // Storage is reset too so the head fields read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= wr_ent;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  assign head         = mem[rd_ptr];
  assign updValid_o   = (count != '0);
  assign updPC_o      = head.pc;
  assign updType_o    = head.typ;
  assign updNPC_o     = head.npc;
  assign updDir_o     = head.dir;
  assign updCtiID_o   = head.cti;
  assign count_o      = count;
  assign almostFull_o = (count >= AFULL_C);
  assign overflow_o   = ovf;

endmodule

// File: tb/tb_ctrl_resolve_queue.sv
module tb_ctrl_resolve_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        recoverFlag_i = 1'b0;
  logic        exeCtrlValid_i = 1'b0;
  logic [31:0] exeCtrlPC_i = '0;
  logic [1:0]  exeCtrlType_i = '0;
  logic [31:0] exeCtrlNPC_i = '0;
  logic        exeCtrlDir_i = 1'b0;
  logic [3:0]  exeCtiID_i = '0;
  logic        updValid_o;
  logic        updReady_i = 1'b0;
  logic [31:0] updPC_o;
  logic [1:0]  updType_o;
  logic [31:0] updNPC_o;
  logic        updDir_o;
  logic [3:0]  updCtiID_o;
  logic [3:0]  count_o;
  logic        almostFull_o;
  logic        overflow_o;

  ctrl_resolve_queue #(.DEPTH(DEPTH), .PC_W(32), .TYPE_W(2), .CTI_W(4), .AFULL_TH(6)) dut (
    .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
    .exeCtrlValid_i(exeCtrlValid_i), .exeCtrlPC_i(exeCtrlPC_i),
    .exeCtrlType_i(exeCtrlType_i), .exeCtrlNPC_i(exeCtrlNPC_i),
    .exeCtrlDir_i(exeCtrlDir_i), .exeCtiID_i(exeCtiID_i),
    .updValid_o(updValid_o), .updReady_i(updReady_i),
    .updPC_o(updPC_o), .updType_o(updType_o), .updNPC_o(updNPC_o),
    .updDir_o(updDir_o), .updCtiID_o(updCtiID_o),
    .count_o(count_o), .almostFull_o(almostFull_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  typ;
    logic [31:0] npc;
    logic        dir;
    logic [3:0]  cti;
  } ent_t;

  typedef struct {
    bit          v;
    bit          rec;
    bit          rdy;
    logic [31:0] pc;
    int          exp_cnt;
    bit          exp_ovf;
  } vec_t;

  ent_t sb[$];
  vec_t tbl[17];
  int   nvec = 0;
  int   nerr = 0;
  int   mcount = 0;
  bit   movf = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, score any pop against the queue model,
  // then check status one step after the rising edge.
  task automatic step(bit v, bit rec, bit rdy, logic [31:0] pc, logic [3:0] cti);
    ent_t e;
    bit push, pop, acc;
    @(negedge clk);
    exeCtrlValid_i = v;
    recoverFlag_i  = rec;
    updReady_i     = rdy;
    exeCtrlPC_i    = pc;
    exeCtrlNPC_i   = pc + 32'd4;
    exeCtrlDir_i   = pc[2];
    exeCtrlType_i  = pc[4:3];
    exeCtiID_i     = cti;
    #1;
    pop = (mcount != 0) && rdy;
    if (pop) begin
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL sb_empty: got pop expected none");
      end else begin
        e = sb.pop_front();
        chk("upd_pc",  updPC_o,    e.pc);
        chk("upd_npc", updNPC_o,   e.npc);
        chk("upd_typ", updType_o,  e.typ);
        chk("upd_dir", updDir_o,   e.dir);
        chk("upd_cti", updCtiID_o, e.cti);
      end
    end
    push = v && !rec;
    acc  = push && (mcount < DEPTH || pop);
    if (acc) sb.push_back('{pc, pc[4:3], pc + 32'd4, pc[2], cti});
    if (push && !acc) movf = 1'b1;
    if (acc && !pop) mcount++;
    else if (pop && !acc) mcount--;
    @(posedge clk);
    #1;
    chk("count", count_o, mcount);
    chk("valid", updValid_o, mcount != 0);
    chk("afull", almostFull_o, mcount >= 6);
    chk("ovf",   overflow_o, movf);
  endtask

  task automatic idle(bit rdy);
    step(1'b0, 1'b0, rdy, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    exeCtrlValid_i = 1'b0;
    updReady_i = 1'b0;
    recoverFlag_i = 1'b0;
    #1;
    chk("rst_valid", updValid_o, 1'b0);
    chk("rst_count", count_o, 4'd0);
    chk("rst_afull", almostFull_o, 1'b0);
    chk("rst_ovf",   overflow_o, 1'b0);
    chk("rst_pc",    updPC_o, 32'h0);
    chk("rst_npc",   updNPC_o, 32'h0);
    chk("rst_fld",   {updType_o, updDir_o, updCtiID_o}, 7'h0);
    sb.delete();
    mcount = 0;
    movf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Fill past full with no drain, then drain: 0x20 is dropped.
    for (int i = 0; i < 9; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 32'(i * 4), (i + 1 > 8) ? 8 : i + 1, i == 8};
    for (int i = 0; i < 8; i++)
      tbl[9 + i] = '{1'b0, 1'b0, 1'b1, 32'h0, 7 - i, 1'b1};

    repeat (2) @(negedge clk);
    do_reset();

    // Basic push, held for 5 cycles with no ready.
    step(1'b1, 1'b0, 1'b0, 32'h1000, 4'd3);
    chk("basic_npc", updNPC_o, 32'h1004);
    chk("basic_cti", updCtiID_o, 4'd3);
    chk("basic_dir", updDir_o, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("hold_pc", updPC_o, 32'h1000);
    end
    idle(1'b1);
    idle(1'b1);  // ready while empty: no effect

    // Table-driven fill/drop/drain.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].rec, tbl[i].rdy, tbl[i].pc, 4'(i));
      chk("tbl_cnt", count_o, tbl[i].exp_cnt);
      chk("tbl_ovf", overflow_o, tbl[i].exp_ovf);
    end

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h40 + 32'(i * 4), 4'(i));
    step(1'b1, 1'b0, 1'b1, 32'hA0, 4'hA);
    chk("fullpp_cnt", count_o, 4'd8);
    chk("fullpp_ovf", overflow_o, 1'b0);
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("fullpp_empty", count_o, 4'd0);

    // Recovery suppresses pushes but not pops.
    step(1'b1, 1'b0, 1'b0, 32'h200, 4'd1);
    step(1'b1, 1'b0, 1'b0, 32'h204, 4'd2);
    step(1'b1, 1'b1, 1'b0, 32'h208, 4'd3);
    chk("rec_cnt", count_o, 4'd2);
    step(1'b1, 1'b1, 1'b1, 32'h20C, 4'd4);
    chk("rec_pop_cnt", count_o, 4'd1);
    idle(1'b1);

    // 20 push/pop pairs across the pointer wrap.
    step(1'b1, 1'b0, 1'b0, 32'h300, 4'd0);
    for (int i = 1; i <= 20; i++) step(1'b1, 1'b0, 1'b1, 32'h300 + 32'(i * 4), 4'(i));
    idle(1'b1);

    // Async reset mid-cycle with 3 entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h400 + 32'(i * 4), 4'(i));
    exeCtrlValid_i = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", updValid_o, 1'b0);
    chk("async_count", count_o, 4'd0);
    chk("async_pc", updPC_o, 32'h0);
    sb.delete();
    mcount = 0;
    movf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h5550, 4'd5);
    chk("post_rst_pc", updPC_o, 32'h5550);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
